// File: rtl/risc_pkg.sv
// Shared definitions for the 5-stage integer core.
//   - Opcode constants of the 32-bit ISA
//   - itype_e: instruction class used by decode, hazard and retire logic
//   - fwd_sel_e: EX operand source select
//   - decode_type(): opcode -> instruction class (undefined opcodes -> ItIllegal)
package risc_pkg;

    localparam logic [5:0] OpAdd   = 6'h00;
    localparam logic [5:0] OpSub   = 6'h01;
    localparam logic [5:0] OpAnd   = 6'h02;
    localparam logic [5:0] OpOr    = 6'h03;
    localparam logic [5:0] OpSlt   = 6'h04;
    localparam logic [5:0] OpMul   = 6'h05;
    localparam logic [5:0] OpHlt   = 6'h06;
    localparam logic [5:0] OpLw    = 6'h08;
    localparam logic [5:0] OpSw    = 6'h09;
    localparam logic [5:0] OpAddi  = 6'h0A;
    localparam logic [5:0] OpSubi  = 6'h0B;
    localparam logic [5:0] OpSlti  = 6'h0C;
    localparam logic [5:0] OpBneqz = 6'h0D;
    localparam logic [5:0] OpBeqz  = 6'h0E;

    typedef enum logic [2:0] {
        ItRr, ItRm, ItLoad, ItStore, ItBranch, ItHalt, ItIllegal
    } itype_e;

    typedef enum logic [1:0] {
        FwdReg, FwdMem, FwdWb
    } fwd_sel_e;

    function automatic itype_e decode_type(input logic [5:0] op);
        itype_e t;
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: t = ItRr;
            OpAddi, OpSubi, OpSlti:                  t = ItRm;
            OpLw:                                    t = ItLoad;
            OpSw:                                    t = ItStore;
            OpBneqz, OpBeqz:                         t = ItBranch;
            OpHlt:                                   t = ItHalt;
            default:                                 t = ItIllegal;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/risc_hazard_unit.sv
// Combinational hazard control for risc_pipe_core.
//   id_*   : instruction in ID (source indices and which sources it reads)
//   ex_*   : instruction in EX (sources for bypass, destination for interlock)
//   mem_*  : instruction in MEM (EX/MEM register), wb_* : instruction in WB (MEM/WB register)
//   branch_taken : taken branch resolved in EX
//   fwd_a / fwd_b : EX operand source for rs / rt
//   stall  : hold PC and IF/ID, insert a bubble into EX
//   flush  : squash IF/ID and ID/EX, redirect fetch
module risc_hazard_unit
    import risc_pkg::*;
#(
    parameter int unsigned RW      = 5,
    parameter bit          FORWARD = 1'b1
) (
    input  logic          id_valid,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          ex_valid,
    input  logic          ex_we,
    input  logic          ex_is_load,
    input  logic [RW-1:0] ex_rs,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] ex_dest,
    input  logic          mem_valid,
    input  logic          mem_we,
    input  logic [RW-1:0] mem_dest,
    input  logic          wb_valid,
    input  logic          wb_we,
    input  logic [RW-1:0] wb_dest,
    input  logic          branch_taken,
    output fwd_sel_e      fwd_a,
    output fwd_sel_e      fwd_b,
    output logic          stall,
    output logic          flush
);

    // A stage produces a value for src only if it is live and really writes a non-R0 register.
    function automatic logic hits(input logic v, input logic we,
                                  input logic [RW-1:0] dest, input logic [RW-1:0] src);
        return v && we && (dest != '0) && (dest == src);
    endfunction

    logic id_dep_ex, id_dep_mem;

    always_comb begin
        id_dep_ex  = id_valid && ((id_uses_rs && hits(ex_valid, ex_we, ex_dest, id_rs)) ||
                                  (id_uses_rt && hits(ex_valid, ex_we, ex_dest, id_rt)));
        id_dep_mem = id_valid && ((id_uses_rs && hits(mem_valid, mem_we, mem_dest, id_rs)) ||
                                  (id_uses_rt && hits(mem_valid, mem_we, mem_dest, id_rt)));

        // Without bypass, wait until producers reach WB (write-first regfile covers WB).
        if (FORWARD) begin
            stall = id_dep_ex && ex_is_load;
        end else begin
            stall = id_dep_ex || id_dep_mem;
        end
        // A taken branch squashes the stalled instruction anyway.
        stall = stall && !branch_taken;
        flush = branch_taken;

        fwd_a = FwdReg;
        fwd_b = FwdReg;
        if (FORWARD) begin
            if (hits(mem_valid, mem_we, mem_dest, ex_rs)) fwd_a = FwdMem;
            else if (hits(wb_valid, wb_we, wb_dest, ex_rs)) fwd_a = FwdWb;
            if (hits(mem_valid, mem_we, mem_dest, ex_rt)) fwd_b = FwdMem;
            else if (hits(wb_valid, wb_we, wb_dest, ex_rt)) fwd_b = FwdWb;
        end
    end

endmodule

// File: rtl/risc_pipe_core.sv
// 5-stage (IF/ID/EX/MEM/WB) integer core with internal instruction and data memories.
//   clk, rst                : single clock, synchronous active-high reset
//   imem_we/waddr/wdata     : program-load write port
//   dbg_raddr / dbg_rdata   : combinational register-file read (R0 -> 0)
//   halted, illegal         : core frozen after HLT/illegal retires; illegal is sticky
//   cycle_cnt, instret_cnt  : cycles while running, retired instructions
module risc_pipe_core
    import risc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter bit          FORWARD    = 1'b1,
    localparam int unsigned PCW       = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_we,
    input  logic [PCW-1:0]  imem_waddr,
    input  logic [31:0]     imem_wdata,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            halted,
    output logic            illegal,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned DW = $clog2(DMEM_DEPTH);

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] regs [NREG];

    logic [PCW-1:0]  pc_q;
    logic            fetch_stop_q, halted_q, illegal_q;
    logic [31:0]     cycle_q, instret_q;
    logic            ifid_valid_q;
    logic [31:0]     ifid_instr_q;
    logic [PCW-1:0]  ifid_npc_q;
    logic            idex_valid_q, idex_we_q;
    itype_e          idex_type_q;
    logic [5:0]      idex_op_q;
    logic [RW-1:0]   idex_rs_q, idex_rt_q, idex_dest_q;
    logic [XLEN-1:0] idex_a_q, idex_b_q, idex_imm_q;
    logic [PCW-1:0]  idex_npc_q;
    logic            exmem_valid_q, exmem_we_q;
    itype_e          exmem_type_q;
    logic [RW-1:0]   exmem_dest_q;
    logic [XLEN-1:0] exmem_res_q, exmem_sdata_q;
    logic            memwb_valid_q, memwb_we_q;
    itype_e          memwb_type_q;
    logic [RW-1:0]   memwb_dest_q;
    logic [XLEN-1:0] memwb_res_q;

    // ID decode and register read
    logic [5:0]      id_op;
    itype_e          id_type;
    logic [RW-1:0]   id_rs, id_rt, id_rd, id_dest;
    logic            id_uses_rs, id_uses_rt, id_we, id_halt;
    logic [XLEN-1:0] id_imm, id_a, id_b;
    logic            wb_write;

    assign wb_write = memwb_valid_q && memwb_we_q && (memwb_dest_q != '0) && !halted_q;

    always_comb begin
        id_op      = ifid_instr_q[31:26];
        id_type    = decode_type(id_op);
        id_rs      = ifid_instr_q[21 +: RW];
        id_rt      = ifid_instr_q[16 +: RW];
        id_rd      = ifid_instr_q[11 +: RW];
        id_imm     = XLEN'($signed(ifid_instr_q[15:0]));
        id_uses_rs = id_type inside {ItRr, ItRm, ItLoad, ItStore, ItBranch};
        id_uses_rt = id_type inside {ItRr, ItStore};
        id_we      = id_type inside {ItRr, ItRm, ItLoad};
        id_dest    = (id_type == ItRr) ? id_rd : id_rt;
        id_halt    = ifid_valid_q && (id_type inside {ItHalt, ItIllegal});
        // Write-first: the value retiring this cycle is visible to the ID read.
        id_a = (id_rs == '0) ? '0 : regs[id_rs];
        id_b = (id_rt == '0) ? '0 : regs[id_rt];
        if (wb_write && memwb_dest_q == id_rs) id_a = memwb_res_q;
        if (wb_write && memwb_dest_q == id_rt) id_b = memwb_res_q;
    end

    // Hazard control
    fwd_sel_e fwd_a, fwd_b;
    logic     stall, flush, ex_taken;

    risc_hazard_unit #(
        .RW      (RW),
        .FORWARD (FORWARD)
    ) u_hazard (
        .id_valid     (ifid_valid_q),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_valid     (idex_valid_q),
        .ex_we        (idex_we_q),
        .ex_is_load   (idex_type_q == ItLoad),
        .ex_rs        (idex_rs_q),
        .ex_rt        (idex_rt_q),
        .ex_dest      (idex_dest_q),
        .mem_valid    (exmem_valid_q),
        .mem_we       (exmem_we_q),
        .mem_dest     (exmem_dest_q),
        .wb_valid     (memwb_valid_q),
        .wb_we        (memwb_we_q),
        .wb_dest      (memwb_dest_q),
        .branch_taken (ex_taken),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .flush        (flush)
    );

    // EX: operand bypass, ALU, branch resolution
    logic [XLEN-1:0] ex_a, ex_rt_val, ex_b, ex_res;
    logic [PCW-1:0]  ex_target;

    always_comb begin
        unique case (fwd_a)
            FwdMem:  ex_a = exmem_res_q;
            FwdWb:   ex_a = memwb_res_q;
            default: ex_a = idex_a_q;
        endcase
        unique case (fwd_b)
            FwdMem:  ex_rt_val = exmem_res_q;
            FwdWb:   ex_rt_val = memwb_res_q;
            default: ex_rt_val = idex_b_q;
        endcase
        ex_b = (idex_type_q == ItRr) ? ex_rt_val : idex_imm_q;
        case (idex_op_q)
            OpSub, OpSubi: ex_res = ex_a - ex_b;
            OpAnd:         ex_res = ex_a & ex_b;
            OpOr:          ex_res = ex_a | ex_b;
            OpSlt, OpSlti: ex_res = XLEN'($signed(ex_a) < $signed(ex_b));
            OpMul:         ex_res = ex_a * ex_b;
            default:       ex_res = ex_a + ex_b;  // ADD/ADDI and LW/SW address
        endcase
        ex_taken  = idex_valid_q && (idex_type_q == ItBranch) &&
                    ((idex_op_q == OpBeqz) == (ex_a == '0));
        ex_target = idex_npc_q + PCW'(idex_imm_q);
    end

    logic [XLEN-1:0] mem_rdata;
    assign mem_rdata = dmem[exmem_res_q[DW-1:0]];

    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst && !halted_q && exmem_valid_q && exmem_type_q == ItStore) begin
            dmem[exmem_res_q[DW-1:0]] <= exmem_sdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[memwb_dest_q] <= memwb_res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            fetch_stop_q  <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
            cycle_q       <= '0;
            instret_q     <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= '0;
            ifid_npc_q    <= '0;
            idex_valid_q  <= 1'b0;
            idex_we_q     <= 1'b0;
            idex_type_q   <= ItRr;
            idex_op_q     <= '0;
            idex_rs_q     <= '0;
            idex_rt_q     <= '0;
            idex_dest_q   <= '0;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_imm_q    <= '0;
            idex_npc_q    <= '0;
            exmem_valid_q <= 1'b0;
            exmem_we_q    <= 1'b0;
            exmem_type_q  <= ItRr;
            exmem_dest_q  <= '0;
            exmem_res_q   <= '0;
            exmem_sdata_q <= '0;
            memwb_valid_q <= 1'b0;
            memwb_we_q    <= 1'b0;
            memwb_type_q  <= ItRr;
            memwb_dest_q  <= '0;
            memwb_res_q   <= '0;
        end else if (!halted_q) begin
            cycle_q <= cycle_q + 32'd1;
            // WB retire
            if (memwb_valid_q) begin
                instret_q <= instret_q + 32'd1;
                if (memwb_type_q inside {ItHalt, ItIllegal}) halted_q  <= 1'b1;
                if (memwb_type_q == ItIllegal)               illegal_q <= 1'b1;
            end
            // MEM -> WB
            memwb_valid_q <= exmem_valid_q;
            memwb_we_q    <= exmem_we_q;
            memwb_type_q  <= exmem_type_q;
            memwb_dest_q  <= exmem_dest_q;
            memwb_res_q   <= (exmem_type_q == ItLoad) ? mem_rdata : exmem_res_q;
            // EX -> MEM
            exmem_valid_q <= idex_valid_q;
            exmem_we_q    <= idex_we_q;
            exmem_type_q  <= idex_type_q;
            exmem_dest_q  <= idex_dest_q;
            exmem_res_q   <= ex_res;
            exmem_sdata_q <= ex_rt_val;
            // ID -> EX
            idex_valid_q <= ifid_valid_q && !flush && !stall;
            idex_we_q    <= id_we;
            idex_type_q  <= id_type;
            idex_op_q    <= id_op;
            idex_rs_q    <= id_rs;
            idex_rt_q    <= id_rt;
            idex_dest_q  <= id_dest;
            idex_a_q     <= id_a;
            idex_b_q     <= id_b;
            idex_imm_q   <= id_imm;
            idex_npc_q   <= ifid_npc_q;
            // IF
            if (flush) begin
                pc_q         <= ex_target;
                ifid_valid_q <= 1'b0;
            end else if (stall) begin
                pc_q <= pc_q;
            end else if (fetch_stop_q || id_halt) begin
                // HLT/illegal in ID kills the younger fetch and stops the front end.
                ifid_valid_q <= 1'b0;
                fetch_stop_q <= 1'b1;
            end else begin
                ifid_valid_q <= 1'b1;
                ifid_instr_q <= imem[pc_q];
                ifid_npc_q   <= pc_q + PCW'(1);
                pc_q         <= pc_q + PCW'(1);
            end
        end
    end

    assign dbg_rdata   = (dbg_raddr[RW-1:0] == '0) ? '0 : regs[dbg_raddr[RW-1:0]];
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_risc_pipe_core.sv
// Self-checking bench: two cores (bypass on / bypass off) run the same programs.
module tb_risc_pipe_core;

    localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND = 6'h02, OR = 6'h03, SLT = 6'h04;
    localparam logic [5:0] MUL = 6'h05, HLT = 6'h06, LW = 6'h08, SW = 6'h09, ADDI = 6'h0A;
    localparam logic [5:0] SUBI = 6'h0B, SLTI = 6'h0C, BNEQZ = 6'h0D, BEQZ = 6'h0E;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_we = 1'b0;
    logic [9:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata, dbg_rdata0;
    logic        halted, halted0, illegal, illegal0;
    logic [31:0] cycle_cnt, cycle_cnt0, instret_cnt, instret_cnt0;

    always #5 clk = ~clk;

    risc_pipe_core #(.FORWARD(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata),
        .halted      (halted),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    risc_pipe_core #(.FORWARD(1'b0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata0),
        .halted      (halted0),
        .illegal     (illegal0),
        .cycle_cnt   (cycle_cnt0),
        .instret_cnt (instret_cnt0)
    );

    int n_err = 0;
    int n_checks = 0;
    logic [31:0] prog [$];
    logic [31:0] r1, r0v;
    logic [31:0] c1_t1, c0_t1;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        is_imm;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [31:0] enc_rr(logic [5:0] op, int rd, int rs, int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rt, int rs, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic rreg(input int idx, output logic [31:0] v1, output logic [31:0] v0);
        dbg_raddr = 5'(idx);
        #1;
        v1 = dbg_rdata;
        v0 = dbg_rdata0;
    endtask

    // Holds reset while writing prog into both instruction memories.
    task automatic load_prog();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < prog.size(); i++) begin
            imem_we    = 1'b1;
            imem_waddr = 10'(i);
            imem_wdata = prog[i];
            @(negedge clk);
        end
        imem_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_to_halt(input string name);
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (halted && halted0) break;
            @(negedge clk);
        end
        chk({name, "_halt"}, {31'd0, halted && halted0}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{"add",   ADD,  1'b0, 16'd7,      16'd5,      32'd12},
            '{"sub",   SUB,  1'b0, 16'd5,      16'd7,      32'hFFFF_FFFE},
            '{"and",   AND,  1'b0, 16'd12,     16'd10,     32'd8},
            '{"or",    OR,   1'b0, 16'd12,     16'd10,     32'd14},
            '{"slt_n", SLT,  1'b0, 16'hFFFD,   16'd2,      32'd1},
            '{"slt_p", SLT,  1'b0, 16'd2,      16'hFFFD,   32'd0},
            '{"mul_n", MUL,  1'b0, 16'hFFFD,   16'd4,      32'hFFFF_FFF4},
            '{"mul_w", MUL,  1'b0, 16'h0100,   16'h0100,   32'h0001_0000},
            '{"addi",  ADDI, 1'b1, 16'd1000,   16'hFFFF,   32'd999},
            '{"subi",  SUBI, 1'b1, 16'd10,     16'd3,      32'd7},
            '{"slti_n", SLTI, 1'b1, 16'hFFFF,  16'd0,      32'd1},
            '{"slti_eq", SLTI, 1'b1, 16'd5,    16'd5,      32'd0}
        };

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_cycle", cycle_cnt, 32'd0);
        chk("rst_instret", instret_cnt, 32'd0);
        rreg(5, r1, r0v);
        chk("rst_r5", r1, 32'd0);

        // ALU table
        foreach (vecs[i]) begin
            if (vecs[i].is_imm)
                prog = '{enc_i(ADDI, 1, 0, vecs[i].a), enc_i(vecs[i].op, 3, 1, vecs[i].b),
                         {HLT, 26'd0}};
            else
                prog = '{enc_i(ADDI, 1, 0, vecs[i].a), enc_i(ADDI, 2, 0, vecs[i].b),
                         enc_rr(vecs[i].op, 3, 1, 2), {HLT, 26'd0}};
            load_prog();
            run_to_halt(vecs[i].name);
            rreg(3, r1, r0v);
            chk({vecs[i].name, "_fwd"}, r1, vecs[i].exp);
            chk({vecs[i].name, "_nofwd"}, r0v, vecs[i].exp);
        end

        // Back-to-back dependency: bypass vs. interlock
        prog = '{enc_i(ADDI, 1, 0, 16'd10), enc_i(ADDI, 2, 0, 16'd20), enc_rr(ADD, 3, 1, 2),
                 {HLT, 26'd0}};
        load_prog();
        run_to_halt("dep");
        rreg(3, r1, r0v);
        chk("dep_r3_fwd", r1, 32'd30);
        chk("dep_r3_nofwd", r0v, 32'd30);
        c1_t1 = cycle_cnt;
        c0_t1 = cycle_cnt0;
        chk("dep_cycles_fwd", c1_t1, 32'd8);
        chk("dep_stall_delta", c0_t1 - c1_t1, 32'd2);
        chk("dep_instret", instret_cnt, 32'd4);

        // Store, load, load-use
        prog = '{enc_i(ADDI, 1, 0, 16'd10), enc_i(ADDI, 3, 1, 16'd20), enc_i(SW, 3, 0, 16'd5),
                 enc_i(LW, 4, 0, 16'd5), enc_rr(ADD, 5, 4, 4), {HLT, 26'd0}};
        load_prog();
        run_to_halt("ldu");
        rreg(5, r1, r0v);
        chk("ldu_r5_fwd", r1, 32'd60);
        chk("ldu_r5_nofwd", r0v, 32'd60);
        chk("ldu_cycles", cycle_cnt, 32'd11);
        chk("ldu_instret", instret_cnt, 32'd6);

        // Counted loop with taken branches
        prog = '{enc_i(ADDI, 1, 0, 16'd3), enc_i(SUBI, 1, 1, 16'd1), enc_i(BNEQZ, 0, 1, 16'hFFFE),
                 {HLT, 26'd0}};
        load_prog();
        run_to_halt("loop");
        rreg(1, r1, r0v);
        chk("loop_r1_fwd", r1, 32'd0);
        chk("loop_r1_nofwd", r0v, 32'd0);
        chk("loop_instret", instret_cnt, 32'd8);
        chk("loop_instret_nofwd", instret_cnt0, 32'd8);
        chk("loop_cycles", cycle_cnt, 32'd16);

        // Squashed store: seed Mem[0]=77, skip a SW of 0, read Mem[0] back
        prog = '{enc_i(ADDI, 1, 0, 16'd77), enc_i(SW, 1, 0, 16'd0), {HLT, 26'd0}};
        load_prog();
        run_to_halt("seed");
        prog = '{enc_i(BEQZ, 0, 0, 16'd2), enc_i(SW, 1, 0, 16'd0), enc_i(ADDI, 7, 0, 16'd1),
                 {HLT, 26'd0}};
        load_prog();
        run_to_halt("sqsw");
        chk("sqsw_instret", instret_cnt, 32'd2);
        rreg(7, r1, r0v);
        chk("sqsw_r7", r1, 32'd0);
        prog = '{enc_i(LW, 2, 0, 16'd0), {HLT, 26'd0}};
        load_prog();
        run_to_halt("rdback");
        rreg(2, r1, r0v);
        chk("sqsw_mem0_fwd", r1, 32'd77);
        chk("sqsw_mem0_nofwd", r0v, 32'd77);

        // Taken branch in EX with HLT in ID: branch wins
        prog = '{enc_i(BEQZ, 0, 0, 16'd2), {HLT, 26'd0}, enc_i(ADDI, 6, 0, 16'd9),
                 enc_i(ADDI, 6, 0, 16'd5), {HLT, 26'd0}};
        load_prog();
        run_to_halt("brhlt");
        rreg(6, r1, r0v);
        chk("brhlt_r6", r1, 32'd5);
        chk("brhlt_instret", instret_cnt, 32'd3);
        chk("brhlt_cycles", cycle_cnt, 32'd9);

        // Illegal opcode halts and sets the sticky flag
        prog = '{enc_i(ADDI, 1, 0, 16'd1), 32'hFC00_0000};
        load_prog();
        run_to_halt("ill");
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_flag_nofwd", {31'd0, illegal0}, 32'd1);
        chk("ill_instret", instret_cnt, 32'd2);

        // Writes to R0 are dropped and never bypassed
        prog = '{enc_i(ADDI, 0, 0, 16'd5), enc_rr(ADD, 8, 0, 0), {HLT, 26'd0}};
        load_prog();
        run_to_halt("r0");
        rreg(8, r1, r0v);
        chk("r0_r8_fwd", r1, 32'd0);
        chk("r0_r8_nofwd", r0v, 32'd0);
        rreg(0, r1, r0v);
        chk("r0_read", r1, 32'd0);

        // Reset pulse mid-loop
        prog = '{enc_i(ADDI, 1, 0, 16'd100), enc_i(SUBI, 1, 1, 16'd1),
                 enc_i(BNEQZ, 0, 1, 16'hFFFE), {HLT, 26'd0}};
        load_prog();
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_running", {31'd0, halted}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cycle", cycle_cnt, 32'd0);
        chk("mid_rst_instret", instret_cnt, 32'd0);
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        rreg(1, r1, r0v);
        chk("mid_rst_r1", r1, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rreg(1, r1, r0v);
        chk("restart_r1", r1, 32'd100);
        chk("restart_instret", instret_cnt, 32'd1);
        chk("restart_cycle", cycle_cnt, 32'd5);

        prog = '{enc_i(SLTI, 6, 0, 16'hFFFF), {HLT, 26'd0}};
        load_prog();
        run_to_halt("slti");
        rreg(6, r1, r0v);
        chk("slti_r6_fwd", r1, 32'd0);
        chk("slti_r6_nofwd", r0v, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
